// File: rtl/vga_anim_pkg.sv
// vga_anim_pkg: shared constants, palette and
// per-axis motion step for the VGA sprite path.
package vga_anim_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int CW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    UPD  = 1'b1
  } upd_state_t;

  localparam logic [7:0][5:0] PALETTE = {
    6'b101010, 6'b111111, 6'b001111, 6'b110011,
    6'b111100, 6'b000011, 6'b001100, 6'b110000
  };

  typedef struct packed {
    logic          dir;
    logic [CW-1:0] pos;
  } step_t;

  // dir=1 moves toward larger coordinates
  function automatic step_t axis_step(
    input logic [CW-1:0] p,
    input logic          dir,
    input logic          wrap,
    input logic [CW-1:0] s,
    input logic [CW-1:0] lim,
    input logic [CW-1:0] rad
  );
    logic [CW:0] pe, se, le, re, sum;
    step_t r;
    pe = {1'b0, p};
    se = {1'b0, s};
    le = {1'b0, lim};
    re = {1'b0, rad};
    sum = pe + se;
    r.dir = dir;
    r.pos = p;
    if (!wrap) begin
      if (dir) begin
        if (sum >= le - re) begin
          r.pos = CW'(le - re - 1'b1);
          r.dir = 1'b0;
        end else begin
          r.pos = CW'(sum);
        end
      end else begin
        if (pe < re + se) begin
          r.pos = rad;
          r.dir = 1'b1;
        end else begin
          r.pos = CW'(pe - se);
        end
      end
    end else begin
      if (dir) begin
        if (sum >= le) r.pos = CW'(sum - le);
        else           r.pos = CW'(sum);
      end else begin
        if (pe < se) r.pos = CW'(pe + le - se);
        else         r.pos = CW'(pe - se);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_hit_pipe.sv
// sprite_hit_pipe: two-stage distance compare of
// the current pixel against one circular sprite.
module sprite_hit_pipe #(
  parameter int X_W    = 10,
  parameter int RADIUS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] hpos,
  input  logic [X_W-1:0] vpos,
  input  logic [X_W-1:0] x,
  input  logic [X_W-1:0] y,
  output logic           in_hit
);

  localparam int SW = 2*X_W + 3;
  localparam logic [SW-1:0] R2 = SW'(RADIUS*RADIUS);

  logic signed [X_W:0]     dx, dy;
  logic signed [2*X_W+1:0] ex, ey, sq_x, sq_y;
  logic [SW-1:0]           d2;

  // S1: signed pixel offsets from the sprite centre
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx <= '0;
      dy <= '0;
    end else begin
      dx <= $signed({1'b0, hpos}) - $signed({1'b0, x});
      dy <= $signed({1'b0, vpos}) - $signed({1'b0, y});
    end
  end

  assign ex   = {{(X_W+1){dx[X_W]}}, dx};
  assign ey   = {{(X_W+1){dy[X_W]}}, dy};
  assign sq_x = ex * ex;
  assign sq_y = ey * ey;
  assign d2   = {1'b0, sq_x} + {1'b0, sq_y};

  // S2: strict inside-circle test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_hit <= 1'b0;
    else        in_hit <= (d2 < R2);
  end

endmodule

// File: rtl/bounce_sprite_engine.sv
// bounce_sprite_engine: moves N sprites once per
// frame in blanking and renders per-pixel hits.
module bounce_sprite_engine
  import vga_anim_pkg::*;
#(
  parameter int N_SPRITES = 2,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int RADIUS    = 32,
  parameter int SPEED_W   = 3,
  parameter int X_W       = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_W-1:0]     hpos,
  input  logic [X_W-1:0]     vpos,
  input  logic               display_on,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               run,
  input  logic               mode,
  input  logic [SPEED_W-1:0] speed,
  output logic               hit,
  output logic [2:0]         hit_id,
  output logic [5:0]         rgb,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               busy
);

  if (N_SPRITES < 1 || N_SPRITES > 8 ||
      N_SPRITES*2*RADIUS > H_ACTIVE) begin : g_bad_cfg
    $error("bounce_sprite_engine: bad sprite config");
  end

  logic [X_W-1:0]       px [N_SPRITES];
  logic [X_W-1:0]       py [N_SPRITES];
  logic [N_SPRITES-1:0] pdx, pdy;

  upd_state_t           state;
  logic [2:0]           idx;
  logic [SPEED_W-1:0]   spd_r;
  logic                 mode_r;
  logic                 trig;

  logic [X_W-1:0]       cur_x, cur_y;
  logic                 cur_dx, cur_dy;
  step_t                stx, sty;
  logic                 unused_step;

  logic [N_SPRITES-1:0] in_vec;
  logic [2:0]           win;
  logic [1:0]           don_d, hs_d, vs_d;

  assign trig = (hpos == '0) && (vpos == X_W'(V_ACTIVE));

  // select the sprite being updated this cycle
  always_comb begin
    cur_x  = px[0];
    cur_y  = py[0];
    cur_dx = pdx[0];
    cur_dy = pdy[0];
    for (int i = 0; i < N_SPRITES; i++) begin
      if (idx == 3'(i)) begin
        cur_x  = px[i];
        cur_y  = py[i];
        cur_dx = pdx[i];
        cur_dy = pdy[i];
      end
    end
    stx = axis_step(CW'(cur_x), cur_dx, mode_r,
                    CW'(spd_r), CW'(H_ACTIVE),
                    CW'(RADIUS));
    sty = axis_step(CW'(cur_y), cur_dy, mode_r,
                    CW'(spd_r), CW'(V_ACTIVE),
                    CW'(RADIUS));
  end

  assign unused_step = ^{stx.pos, sty.pos};

  // motion FSM: one sprite per cycle after trigger
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      spd_r  <= '0;
      mode_r <= 1'b0;
      busy   <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        px[i]  <= X_W'(RADIUS + i*2*RADIUS);
        py[i]  <= X_W'(V_ACTIVE/2);
        pdx[i] <= (i % 2 == 0);
        pdy[i] <= (i % 2 == 0);
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (trig && run) begin
            state  <= UPD;
            idx    <= '0;
            spd_r  <= speed;
            mode_r <= mode;
            busy   <= 1'b1;
          end
        end
        UPD: begin
          for (int i = 0; i < N_SPRITES; i++) begin
            if (idx == 3'(i)) begin
              px[i]  <= stx.pos[X_W-1:0];
              pdx[i] <= stx.dir;
              py[i]  <= sty.pos[X_W-1:0];
              pdy[i] <= sty.dir;
            end
          end
          if (idx == 3'(N_SPRITES-1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_pipe
    sprite_hit_pipe #(
      .X_W    (X_W),
      .RADIUS (RADIUS)
    ) u_pipe (
      .clk    (clk),
      .rst_n  (rst_n),
      .hpos   (hpos),
      .vpos   (vpos),
      .x      (px[g]),
      .y      (py[g]),
      .in_hit (in_vec[g])
    );
  end

  // two-stage delay of visibility and sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      don_d <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
    end else begin
      don_d <= {don_d[0], display_on};
      hs_d  <= {hs_d[0], hsync};
      vs_d  <= {vs_d[0], vsync};
    end
  end

  // lowest sprite index wins
  always_comb begin
    win = '0;
    for (int i = N_SPRITES-1; i >= 0; i--) begin
      if (in_vec[i]) win = 3'(i);
    end
  end

  assign hit     = (|in_vec) & don_d[1];
  assign hit_id  = hit ? win : 3'd0;
  assign rgb     = hit ? PALETTE[hit_id] : 6'd0;
  assign hsync_d = hs_d[1];
  assign vsync_d = vs_d[1];

endmodule
